audio_tx_buffer: RTL

//   Playback sample buffer feeding the WM8978 serial transmitter. Accepts 32-bit

---
 rtl/audio_tx_buffer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/audio_tx_buffer.sv
`timescale 1ns/1ps
// audio_tx_buffer
//   Playback sample buffer for the WM8978 serial transmitter. The DSP side writes
//   32-bit samples into a FIFO. The transmitter pulses tx_done once per frame, and
//   the next sample is then presented on dac_data. Playback waits until PREFILL
//   samples are buffered. If the FIFO runs dry during playback, the buffer outputs
//   silence, counts an underrun and primes again.
// Ports
//   aud_bclk     in   bit clock, the only clock (posedge)
//   sys_rst      in   asynchronous active-low reset
//   clr          in   synchronous flush back to IDLE with counters cleared
//   wr_en        in   write request
//   wr_data      in   sample to store
//   full         out  FIFO holds DEPTH entries
//   level        out  occupancy 0..DEPTH
//   tx_done      in   frame-sent pulse from the transmitter
//   dac_data     out  registered sample presented to the transmitter
//   running      out  high while in RUN
//   underrun_cnt out  saturating underrun counter
//   ovf          out  sticky: a write was attempted while full
module audio_tx_buffer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int PREFILL = 8
) (
  input  logic          aud_bclk,
  input  logic          sys_rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  output logic          full,
  output logic [AW:0]   level,
  input  logic          tx_done,
  output logic [31:0]   dac_data,
  output logic          running,
  output logic [15:0]   underrun_cnt,
  output logic          ovf
);

  localparam logic [0:0]  ST_IDLE     = 1'b0;
  localparam logic [0:0]  ST_RUN      = 1'b1;
  localparam logic [AW:0] PTR_ONE     = (AW+1)'(1);
  localparam logic [AW:0] PREFILL_LVL = (AW+1)'(PREFILL);

  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic [0:0]  state_reg;
  logic [31:0] dac_data_reg;
  logic [15:0] underrun_cnt_reg;
  logic        ovf_reg;
  logic        running_reg;

  logic empty;
  logic wr_accept;
  logic pop;
  logic underrun;

  // The pointers carry one extra wrap bit. Two pointers that differ only in
  // that bit mean the FIFO is full. Two equal pointers mean it is empty.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level = wr_ptr_reg - rd_ptr_reg;

  // The flags come from registered pointers. As a result, a pop does not free
  // space for a write in the same cycle. A write into an empty FIFO is also not
  // visible to a tx_done in the same cycle.
  assign wr_accept = wr_en && !full && !clr;
  assign pop       = tx_done && (state_reg == ST_RUN) && !empty && !clr;
  assign underrun  = tx_done && (state_reg == ST_RUN) && empty && !clr;

  // The storage array has no reset so that it maps onto RAM.
  always_ff @(posedge aud_bclk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge aud_bclk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      state_reg        <= ST_IDLE;
      running_reg      <= 1'b0;
      dac_data_reg     <= '0;
      underrun_cnt_reg <= '0;
      ovf_reg          <= 1'b0;
    end else if (clr) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      state_reg        <= ST_IDLE;
      running_reg      <= 1'b0;
      dac_data_reg     <= '0;
      underrun_cnt_reg <= '0;
      ovf_reg          <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end else if (wr_en) begin
        ovf_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          // While priming, every frame plays silence and nothing is consumed.
          if (tx_done) begin
            dac_data_reg <= '0;
          end
          if (level >= PREFILL_LVL) begin
            state_reg   <= ST_RUN;
            running_reg <= 1'b1;
          end
        end
        default: begin
          if (pop) begin
            dac_data_reg <= mem[rd_ptr_reg[AW-1:0]];
            rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
          end else if (underrun) begin
            dac_data_reg <= '0;
            if (underrun_cnt_reg != 16'hFFFF) begin
              underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
            end
            state_reg   <= ST_IDLE;
            running_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  assign dac_data     = dac_data_reg;
  assign running      = running_reg;
  assign underrun_cnt = underrun_cnt_reg;
  assign ovf          = ovf_reg;

endmodule
